// File: rtl/seq_alu_core.sv
// seq_alu_core: registered, handshaked ALU.
// SUB and NAND finish on the accepting edge. Leading-ones and one-hot
// decode of {B,A} walk the operand one bit per clock, MSB first.
module seq_alu_core #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_y,
   output logic             o_overflow,
   output logic             o_err,
   input  logic             i_clr,
   output logic             o_ovf_sticky,
   output logic             o_err_sticky
);
   localparam int CW = 2 * WIDTH;
   localparam int IW = $clog2(CW);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    c_q, c_n;
   logic [1:0]       op_q, op_n;
   logic [IW-1:0]    idx_q, idx_n;
   logic [CW:0]      cnt_q, cnt_n;
   logic [IW-1:0]    pos_q, pos_n;
   logic             seen_q, seen_n;
   logic             eint_q, eint_n;
   logic [WIDTH-1:0] y_q, y_n;
   logic             ovf_q, ovf_n;
   logic             err_q, err_n;
   logic [WIDTH-1:0] diff;
   logic             cur_bit;
   logic [CW:0]      pos_ext;
   logic             handoff;

   assign o_ready    = (state == IDLE);
   assign o_valid    = (state == DONE);
   assign o_y        = y_q;
   assign o_overflow = ovf_q;
   assign o_err      = err_q;
   assign handoff    = o_valid && i_ready;

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         c_q    <= '0;
         op_q   <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
         pos_q  <= '0;
         seen_q <= 1'b0;
         eint_q <= 1'b0;
         y_q    <= '0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         c_q    <= c_n;
         op_q   <= op_n;
         idx_q  <= idx_n;
         cnt_q  <= cnt_n;
         pos_q  <= pos_n;
         seen_q <= seen_n;
         eint_q <= eint_n;
         y_q    <= y_n;
         ovf_q  <= ovf_n;
         err_q  <= err_n;
      end
   end

   // Next state, scan step and result formation
   always_comb begin
      state_n = state;
      c_n     = c_q;
      op_n    = op_q;
      idx_n   = idx_q;
      cnt_n   = cnt_q;
      pos_n   = pos_q;
      seen_n  = seen_q;
      eint_n  = eint_q;
      y_n     = y_q;
      ovf_n   = ovf_q;
      err_n   = err_q;
      diff    = i_a - i_b;
      cur_bit = c_q[idx_q];
      pos_ext = '0;
      case (state)
         IDLE: begin
            if (i_valid) begin
               c_n  = {i_b, i_a};
               op_n = i_op;
               case (i_op)
                  2'b00: begin
                     y_n     = diff;
                     ovf_n   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                               (diff[WIDTH-1] != i_a[WIDTH-1]);
                     err_n   = 1'b0;
                     state_n = DONE;
                  end
                  2'b01: begin
                     y_n     = ~(i_a & i_b);
                     ovf_n   = 1'b0;
                     err_n   = 1'b0;
                     state_n = DONE;
                  end
                  default: begin
                     idx_n   = IW'(CW - 1);
                     cnt_n   = '0;
                     pos_n   = '0;
                     seen_n  = 1'b0;
                     eint_n  = 1'b0;
                     state_n = SCAN;
                  end
               endcase
            end
         end
         SCAN: begin
            if (op_q == 2'b10) begin
               // Leading ones: stop at the first zero or after bit 0
               if (cur_bit) cnt_n = cnt_q + (CW+1)'(1);
               if (!cur_bit || idx_q == '0) begin
                  y_n     = cnt_n[WIDTH-1:0];
                  ovf_n   = |cnt_n[CW:WIDTH];
                  err_n   = 1'b0;
                  state_n = DONE;
               end else begin
                  idx_n = idx_q - IW'(1);
               end
            end else begin
               // One-hot: always full length; last set bit seen is the lowest
               if (cur_bit) begin
                  if (seen_q) eint_n = 1'b1;
                  pos_n  = idx_q;
                  seen_n = 1'b1;
               end
               if (idx_q == '0) begin
                  pos_ext = (CW+1)'(pos_n);
                  y_n     = pos_ext[WIDTH-1:0];
                  ovf_n   = |pos_ext[CW:WIDTH];
                  err_n   = eint_n || !seen_n;
                  state_n = DONE;
               end else begin
                  idx_n = idx_q - IW'(1);
               end
            end
         end
         DONE: begin
            if (i_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Sticky flags: clear first, then OR in the flags of a same-cycle handoff
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ovf_sticky <= 1'b0;
         o_err_sticky <= 1'b0;
      end else if (handoff) begin
         o_ovf_sticky <= (o_ovf_sticky && !i_clr) || ovf_q;
         o_err_sticky <= (o_err_sticky && !i_clr) || err_q;
      end else if (i_clr) begin
         o_ovf_sticky <= 1'b0;
         o_err_sticky <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core (WIDTH=4 main instance, WIDTH=2 for count overflow).
module tb_seq_alu_core;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_valid, i_ready, i_clr;
   logic [1:0] i_op;
   logic [3:0] i_a, i_b;
   logic       o_ready, o_valid, o_overflow, o_err, o_ovf_sticky, o_err_sticky;
   logic [3:0] o_y;

   logic       w_valid, w_ready_in, w_clr;
   logic [1:0] w_op;
   logic [1:0] w_a, w_b;
   logic       w_ready, w_ovalid, w_ovf, w_err, w_ovf_st, w_err_st;
   logic [1:0] w_y;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_alu_core #(.WIDTH(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
      .o_y(o_y), .o_overflow(o_overflow), .o_err(o_err), .i_clr(i_clr),
      .o_ovf_sticky(o_ovf_sticky), .o_err_sticky(o_err_sticky)
   );

   seq_alu_core #(.WIDTH(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(w_valid), .o_ready(w_ready),
      .i_op(w_op), .i_a(w_a), .i_b(w_b), .o_valid(w_ovalid), .i_ready(w_ready_in),
      .o_y(w_y), .o_overflow(w_ovf), .o_err(w_err), .i_clr(w_clr),
      .o_ovf_sticky(w_ovf_st), .o_err_sticky(w_err_st)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Issue one op on the WIDTH=4 core; lat counts edges from the accepting
   // edge (inclusive) until o_valid is seen. Result is left pending.
   task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        output int lat);
      int t;
      t = 0;
      while (!o_ready && t < 50) begin tick(); t++; end
      i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
      tick();
      i_valid = 1'b0; i_a = 4'hx; i_b = 4'hx; i_op = 2'bxx;
      lat = 1;
      while (!o_valid && lat < 100) begin tick(); lat++; end
      if (!o_valid) begin
         checks++; failures++;
         $display("FAIL timeout: o_valid never rose (op=%0d)", op);
      end
   endtask

   task automatic handoff();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({o_valid, o_ready, o_y, o_overflow, o_err, o_ovf_sticky, o_err_sticky} !== 10'b01_0000_0000) begin
         failures++;
         $display("FAIL reset: valid=%b ready=%b y=%b ovf=%b err=%b sticky=%b%b, want 0 1 0000 0 0 00",
                  o_valid, o_ready, o_y, o_overflow, o_err, o_ovf_sticky, o_err_sticky);
      end
   endtask

   task automatic test_sub();
      int lat;
      issue(2'b00, 4'd3, 4'b1011, lat);
      checks++;
      if (lat !== 1 || o_y !== 4'b1000 || o_overflow !== 1'b1 || o_err !== 1'b0) begin
         failures++;
         $display("FAIL sub_3_m5: lat=%0d y=%b ovf=%b err=%b, want 1 1000 1 0", lat, o_y, o_overflow, o_err);
      end
      handoff();
      checks++;
      if (o_ovf_sticky !== 1'b1 || o_err_sticky !== 1'b0 || o_valid !== 1'b0) begin
         failures++;
         $display("FAIL sub_sticky: ovf_st=%b err_st=%b valid=%b, want 1 0 0", o_ovf_sticky, o_err_sticky, o_valid);
      end
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
      checks++;
      if (o_ovf_sticky !== 1'b0) begin
         failures++;
         $display("FAIL clr_sticky: ovf_st=%b, want 0", o_ovf_sticky);
      end
   endtask

   task automatic test_nand_hold();
      int lat;
      int bad;
      issue(2'b01, 4'b1100, 4'b1010, lat);
      checks++;
      if (lat !== 1 || o_y !== 4'b0111 || o_overflow !== 1'b0 || o_err !== 1'b0) begin
         failures++;
         $display("FAIL nand: lat=%0d y=%b ovf=%b err=%b, want 1 0111 0 0", lat, o_y, o_overflow, o_err);
      end
      // New request presented while the result is stalled
      i_op = 2'b00; i_a = 4'd5; i_b = 4'd1; i_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_valid !== 1'b1 || o_y !== 4'b0111 || o_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL nand_hold: %0d unstable cycles (valid=%b y=%b ready=%b), want 0", bad, o_valid, o_y, o_ready);
      end
      handoff();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL no_accept_on_handoff: valid=%b ready=%b, want 0 1", o_valid, o_ready);
      end
      i_valid = 1'b0;
   endtask

   task automatic test_lones();
      int lat;
      // Edge 1 enters SCAN; remaining edges are scan cycles (count k -> k+1).
      issue(2'b10, 4'b0000, 4'b0000, lat);
      checks++;
      if (lat - 1 !== 1 || o_y !== 4'd0 || o_overflow !== 1'b0 || o_err !== 1'b0) begin
         failures++;
         $display("FAIL lones_zero: scan=%0d y=%0d ovf=%b err=%b, want 1 0 0 0", lat - 1, o_y, o_overflow, o_err);
      end
      handoff();
      issue(2'b10, 4'b1100, 4'b1111, lat);
      checks++;
      if (lat - 1 !== 7 || o_y !== 4'd6 || o_overflow !== 1'b0 || o_err !== 1'b0) begin
         failures++;
         $display("FAIL lones_six: scan=%0d y=%0d ovf=%b err=%b, want 7 6 0 0", lat - 1, o_y, o_overflow, o_err);
      end
      handoff();
      issue(2'b10, 4'b1111, 4'b1111, lat);
      checks++;
      if (lat - 1 !== 8 || o_y !== 4'd8 || o_overflow !== 1'b0) begin
         failures++;
         $display("FAIL lones_all: scan=%0d y=%0d ovf=%b, want 8 8 0", lat - 1, o_y, o_overflow);
      end
      handoff();
   endtask

   task automatic test_onehot();
      int lat;
      issue(2'b11, 4'b0001, 4'b0100, lat);
      checks++;
      if (o_y !== 4'd0 || o_err !== 1'b1 || o_overflow !== 1'b0) begin
         failures++;
         $display("FAIL onehot_two: y=%0d err=%b ovf=%b, want 0 1 0", o_y, o_err, o_overflow);
      end
      handoff();
      issue(2'b11, 4'b0000, 4'b0000, lat);
      checks++;
      if (o_y !== 4'd0 || o_err !== 1'b1 || lat - 1 !== 8) begin
         failures++;
         $display("FAIL onehot_none: y=%0d err=%b scan=%0d, want 0 1 8", o_y, o_err, lat - 1);
      end
      handoff();
      issue(2'b11, 4'b0000, 4'b0100, lat);
      checks++;
      if (o_y !== 4'd6 || o_err !== 1'b0 || o_overflow !== 1'b0 || lat - 1 !== 8) begin
         failures++;
         $display("FAIL onehot_six: y=%0d err=%b ovf=%b scan=%0d, want 6 0 0 8", o_y, o_err, o_overflow, lat - 1);
      end
      handoff();
      checks++;
      if (o_err_sticky !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: got %b, want 1", o_err_sticky);
      end
   endtask

   task automatic test_mid_reset();
      int lat;
      i_op = 2'b10; i_a = 4'b1111; i_b = 4'b1111; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_y !== 4'd0 || o_err_sticky !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset: valid=%b y=%0d err_st=%b ready=%b, want 0 0 0 1", o_valid, o_y, o_err_sticky, o_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         failures++;
         $display("FAIL after_reset: ready=%b valid=%b, want 1 0", o_ready, o_valid);
      end
      issue(2'b00, 4'd2, 4'd1, lat);
      checks++;
      if (lat !== 1 || o_y !== 4'd1 || o_overflow !== 1'b0) begin
         failures++;
         $display("FAIL sub_after_reset: lat=%0d y=%0d ovf=%b, want 1 1 0", lat, o_y, o_overflow);
      end
      handoff();
   endtask

   task automatic test_w2_overflow();
      int lat;
      w_op = 2'b10; w_a = 2'b11; w_b = 2'b11; w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      lat = 1;
      while (!w_ovalid && lat < 100) begin tick(); lat++; end
      checks++;
      if (w_ovalid !== 1'b1 || lat - 1 !== 4 || w_y !== 2'b00 || w_ovf !== 1'b1 || w_err !== 1'b0) begin
         failures++;
         $display("FAIL w2_lones_ovf: valid=%b scan=%0d y=%b ovf=%b err=%b, want 1 4 00 1 0",
                  w_ovalid, lat - 1, w_y, w_ovf, w_err);
      end
      w_ready_in = 1'b1;
      tick();
      w_ready_in = 1'b0;
      checks++;
      if (w_ovf_st !== 1'b1) begin
         failures++;
         $display("FAIL w2_ovf_sticky: got %b, want 1", w_ovf_st);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      i_valid = 1'b0; i_ready = 1'b0; i_clr = 1'b0; i_op = '0; i_a = '0; i_b = '0;
      w_valid = 1'b0; w_ready_in = 1'b0; w_clr = 1'b0; w_op = '0; w_a = '0; w_b = '0;
      repeat (2) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_sub();
      test_nand_hold();
      test_lones();
      test_onehot();
      test_mid_reset();
      test_w2_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
